lpm_sipo_rx: RTL and testbench
==============================

# lpm_sipo_rx

Serial-to-parallel receiver for the LPM library, and the receiving end of a serial link whose transmitter is an `lpm_shiftreg` loaded in parallel and shifted out through `shiftout`. It samples `shiftin` on enabled clock edges and assembles `lpm_width` bits into a word, with a frame marker on the first bit. The finished word goes into a holding register with a valid/ready handshake. The block sits between a serial pin or link and a parallel consumer, and reports overrun and aborted-frame conditions.

## Interface
- `lpm_type`, "lpm_sipo_rx", type tag.
- `lpm_width`, 8, word width in bits; legal range ≥1.
- `lpm_direction`, "LEFT", "LEFT" = MSB first (matches a LEFT-shifting transmitter); "RIGHT" = LSB first; "UNUSED" behaves as "LEFT".
- `lpm_hint`, "UNUSED", ignored.
- `clock`  in  1  rising-edge clock.
- `sclr_n`  in  1  reset, synchronous and active-low.
- `enable`  in  1  bit strobe; shiftin/frame sampled only when high.
- `shiftin`  in  1  serial data bit.
- `frame`  in  1  marks the first bit of a word; qualified by enable.
- `q_ready`  in  1  consumer accepts the word in q.
- `q`  out  lpm_width  received word.
- `q_valid`  out  1  q holds an unaccepted word.
- `busy`  out  1  a word is in progress (state ≠ IDLE).
- `overrun`  out  1  one-cycle pulse: a completed word was dropped.
- `abort`  out  1  one-cycle pulse: a partial word was discarded by a new frame.
- `parity_err`  out  1  parity status of the word in q.

## Operation
- States:
  - IDLE: bits with enable=1 and frame=0 are ignored. enable=1 and frame=1 samples bit 0, sets count=1, and goes to SHIFT. With lpm_width=1 the word instead completes on that same edge.
  - SHIFT: each enable=1 edge samples a bit and increments count. The edge where count reaches lpm_width completes the word and returns to IDLE. With the parity option it goes to PARITY instead.
  - PARITY (option only): the next enable=1 edge samples the parity bit, completes the word and returns to IDLE.
- Shift rule:
  - LEFT: sr ← {sr[w-2:0], shiftin}.
  - RIGHT: sr ← {shiftin, sr[w-1:1]}.
- Counter width is clog2(lpm_width+1). The count never wraps; it is cleared on completion or abort.
- `frame` in SHIFT or PARITY: the partial word is discarded and `abort` pulses. The current bit is taken as bit 0 of a new word (count=1).
- `frame` on the completing edge of SHIFT has no special meaning: the bit is data, not a restart.
- enable=0: state, count, sr and frame are all frozen and ignored. The handshake still operates.
- Completion:
  - q_valid=0, or q_valid=1 with q_ready=1 on the same edge: q ← sr', q_valid stays 1.
  - q_valid=1 with q_ready=0: the new word is dropped, q is retained, and `overrun` pulses.
- `q_ready` with q_valid=1 and no completion: q_valid ← 0 and q is retained.
- `q_ready` with q_valid=0 is ignored.
- Reset (sclr_n=0 at an edge) overrides everything, including mid-word: state=IDLE, count=0, sr=0, q=0, q_valid=0, overrun=0, abort=0, parity_err=0, busy=0.

## Timing
- All outputs are registered and change only on rising `clock`.
- Latency, with enable continuously high and frame sampled at edge k:
  - q/q_valid are visible after edge k+lpm_width−1 without parity, and after edge k+lpm_width with parity.
- Back-to-back words are supported: frame may be sampled on the edge immediately after the completing edge. No gap cycle is needed.
- `overrun` and `abort` are high for exactly the one cycle after the causing edge.
- `busy` goes high after the frame edge and low after the completing edge.

## Configuration
- Macro: `LPM_SIPO_RX_PARITY_EN`.
- Defined:
  - One even-parity bit follows each word, received in the PARITY state.
  - `parity_err` is loaded together with q and equals (XOR of data bits) ≠ parity bit.
  - It is held with q and dropped along with an overrun word.
- Undefined:
  - There is no PARITY state.
  - `parity_err` is tied 0. The port stays present.

## Structure
- Package `lpm_sipo_pkg` holds:
  - the state enum (IDLE, SHIFT, PARITY);
  - the direction constants;
  - a clog2 function for the counter width.
- Sub-module `lpm_sipo_bitctr` holds the bit counter with clear, increment and terminal-count output; it is parameterised by lpm_width.
- The FSM, shift register and output holding register stay in the top module.

## Test plan
- width=8, LEFT, frame with first bit, serial 0,0,0,1,1,1,1,0 → q=0x1E, q_valid=1 after the 8th edge, busy low after it.
- Same stimulus with RIGHT → q=0x78.
- Two back-to-back words 0x1E then 0xC3 with q_ready=0 → q stays 0x1E, one-cycle overrun after the 16th edge. Then q_ready=1 → q_valid=0.
- frame again at bit 4 of a word, then 8 bits of 0x55 → one-cycle abort after that edge; q=0x55, with no word emitted for the aborted one.
- enable toggling 1,0 every cycle while sending 0xA5 → q=0xA5 after 16 clocks. Separately, sclr_n=0 at bit 5 → all outputs 0, and the next frame receives cleanly.
- With `LPM_SIPO_RX_PARITY_EN`: send 0x1E + parity 0 → parity_err=0; send 0x1E + parity 1 → parity_err=1, and latency grows by one edge.

Source files
------------

// File: rtl/lpm_sipo_pkg.sv
// lpm_sipo_pkg: shared state encoding, direction names and counter sizing for the LPM serial receiver
package lpm_sipo_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
  localparam string DIR_LEFT = "LEFT";
  localparam string DIR_RIGHT = "RIGHT";
  localparam string DIR_UNUSED = "UNUSED";
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/lpm_sipo_bitctr.sv
// lpm_sipo_bitctr: received-bit counter with clear, increment and last-bit flag
module lpm_sipo_bitctr import lpm_sipo_pkg::*; #(
  parameter int lpm_width = 8,
  localparam int cw = clog2(lpm_width + 1)
) (
  input  logic clock,
  input  logic sclr_n,
  input  logic clr,
  input  logic inc,
  output logic last
);
  logic [cw-1:0] count;
  // clr together with inc restarts the count at 1 for a frame bit
  always_ff @(posedge clock) begin
    if (!sclr_n) count <= '0;
    else if (clr) count <= cw'(inc);
    else if (inc) count <= count + 1'b1;
  end
  assign last = count == cw'(lpm_width - 1);
endmodule

// File: rtl/lpm_sipo_rx.sv
// lpm_sipo_rx: serial-to-parallel receiver with valid/ready holding register.
// Defining LPM_SIPO_RX_PARITY_EN adds one even-parity bit after each word.
module lpm_sipo_rx import lpm_sipo_pkg::*; #(
  parameter string lpm_type = "lpm_sipo_rx",
  parameter int lpm_width = 8,
  parameter string lpm_direction = "LEFT",
  parameter string lpm_hint = "UNUSED"
) (
  input  logic                 clock,
  input  logic                 sclr_n,
  input  logic                 enable,
  input  logic                 shiftin,
  input  logic                 frame,
  input  logic                 q_ready,
  output logic [lpm_width-1:0] q,
  output logic                 q_valid,
  output logic                 busy,
  output logic                 overrun,
  output logic                 abort,
  output logic                 parity_err
);
`ifdef LPM_SIPO_RX_PARITY_EN
  localparam bit par_en = 1'b1;
`else
  localparam bit par_en = 1'b0;
`endif
  localparam bit msb_first = lpm_direction != DIR_RIGHT;
  if (lpm_width < 1 || lpm_type == "" || lpm_hint == "" ||
      !(lpm_direction == DIR_LEFT || lpm_direction == DIR_RIGHT || lpm_direction == DIR_UNUSED)) begin : g_bad_param
    $error("lpm_sipo_rx: illegal parameter");
  end
  state_t state, state_nx;
  logic [lpm_width-1:0] sr, sr_sh, sr_nx, word;
  logic last, start, data_shift, data_done, par_done, complete, perr_nx, perr_q;
  lpm_sipo_bitctr #(.lpm_width(lpm_width)) u_ctr (
    .clock(clock),
    .sclr_n(sclr_n),
    .clr(start | data_done),
    .inc(data_shift & ~data_done),
    .last(last)
  );
  if (lpm_width == 1) begin : g_one
    assign sr_sh = shiftin;
  end else if (msb_first) begin : g_left
    assign sr_sh = {sr[lpm_width-2:0], shiftin};
  end else begin : g_right
    assign sr_sh = {shiftin, sr[lpm_width-1:1]};
  end
  // a frame on the completing data edge is plain data, everywhere else it restarts
  always_comb begin
    start = enable & frame & (state == IDLE | state == PARITY | (state == SHIFT & ~last));
    data_shift = enable & (start | state == SHIFT);
    data_done = data_shift & (start ? lpm_width == 1 : last);
    par_done = par_en & enable & state == PARITY & ~frame;
    sr_nx = data_shift ? sr_sh : sr;
    complete = par_en ? par_done : data_done;
    word = par_en ? sr : sr_nx;
    perr_nx = ^sr ^ shiftin;
    state_nx = data_done ? (par_en ? PARITY : IDLE) : data_shift ? SHIFT : par_done ? IDLE : state;
  end
  always_ff @(posedge clock) begin
    if (!sclr_n) state <= IDLE;
    else state <= state_nx;
  end
  always_ff @(posedge clock) begin
    if (!sclr_n) begin
      sr <= '0;
      q <= '0;
      q_valid <= 1'b0;
      overrun <= 1'b0;
      abort <= 1'b0;
      perr_q <= 1'b0;
    end else begin
      sr <= sr_nx;
      overrun <= complete & q_valid & ~q_ready;
      abort <= start & state != IDLE;
      if (complete && (!q_valid || q_ready)) begin
        q <= word;
        q_valid <= 1'b1;
        perr_q <= perr_nx;
      end else if (!complete && q_ready) begin
        q_valid <= 1'b0;
      end
    end
  end
  assign busy = state != IDLE;
  assign parity_err = par_en & perr_q;
endmodule

// File: tb/tb_lpm_sipo_rx.sv
// tb_lpm_sipo_rx: directed + random checks of LEFT and RIGHT receivers against a bit-queue reference model
module tb_lpm_sipo_rx;
  localparam int W = 8;
`ifdef LPM_SIPO_RX_PARITY_EN
  localparam bit par = 1'b1;
`else
  localparam bit par = 1'b0;
`endif
  logic clock = 0, sclr_n = 0, enable = 0, frame = 0, shiftin = 0, q_ready = 0;
  logic [W-1:0] q_l, q_r;
  logic qv_l, qv_r, busy_l, busy_r, ov_l, ov_r, ab_l, ab_r, pe_l, pe_r;
  int n_vec = 0, n_bad = 0;
  bit m_bits[$];
  logic [W-1:0] m_ql = 0, m_qr = 0;
  bit m_qv = 0, m_ov = 0, m_ab = 0, m_pe = 0, m_pw = 0;
  always #5 clock = ~clock;
  lpm_sipo_rx #(.lpm_width(W), .lpm_direction("LEFT")) u_left (
    .clock(clock), .sclr_n(sclr_n), .enable(enable), .shiftin(shiftin), .frame(frame), .q_ready(q_ready),
    .q(q_l), .q_valid(qv_l), .busy(busy_l), .overrun(ov_l), .abort(ab_l), .parity_err(pe_l)
  );
  lpm_sipo_rx #(.lpm_width(W), .lpm_direction("RIGHT")) u_right (
    .clock(clock), .sclr_n(sclr_n), .enable(enable), .shiftin(shiftin), .frame(frame), .q_ready(q_ready),
    .q(q_r), .q_valid(qv_r), .busy(busy_r), .overrun(ov_r), .abort(ab_r), .parity_err(pe_r)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // Word-level model: collect bits in arrival order, build the word only when it is complete
  task automatic model();
    bit done;
    bit pbit;
    logic [W-1:0] wl, wr;
    done = 0;
    pbit = 0;
    m_ov = 0;
    m_ab = 0;
    if (!sclr_n) begin
      m_bits.delete();
      m_pw = 0;
      m_ql = 0;
      m_qr = 0;
      m_qv = 0;
      m_pe = 0;
      return;
    end
    if (enable && (m_bits.size() > 0 || frame)) begin
      if (m_bits.size() > 0 && frame && (m_pw || m_bits.size() != W - 1)) begin
        m_ab = 1;
        m_bits.delete();
        m_pw = 0;
      end
      if (m_pw) begin
        done = 1;
        pbit = shiftin;
        m_pw = 0;
      end else begin
        m_bits.push_back(shiftin);
        if (m_bits.size() == W) begin
          if (par) m_pw = 1;
          else done = 1;
        end
      end
    end
    if (done) begin
      wl = 0;
      wr = 0;
      foreach (m_bits[i]) begin
        wl = (wl << 1) | W'(m_bits[i]);
        wr[i] = m_bits[i];
      end
      m_bits.delete();
      if (!m_qv || q_ready) begin
        m_ql = wl;
        m_qr = wr;
        m_qv = 1;
        m_pe = par && ((^wl) != pbit);
      end else m_ov = 1;
    end else if (q_ready) m_qv = 0;
  endtask
  task automatic step(input logic en, input logic fr, input logic si, input logic rdy, input logic rn = 1'b1);
    enable = en;
    frame = fr;
    shiftin = si;
    q_ready = rdy;
    sclr_n = rn;
    @(posedge clock);
    model();
    #1;
    check("q_left", q_l, m_ql);
    check("q_right", q_r, m_qr);
    check("valid_left", qv_l, m_qv);
    check("valid_right", qv_r, m_qv);
    check("busy_left", busy_l, m_bits.size() > 0);
    check("busy_right", busy_r, m_bits.size() > 0);
    check("overrun_left", ov_l, m_ov);
    check("overrun_right", ov_r, m_ov);
    check("abort_left", ab_l, m_ab);
    check("abort_right", ab_r, m_ab);
    check("perr_left", pe_l, m_pe);
    check("perr_right", pe_r, m_pe);
  endtask
  task automatic send_par(input logic [7:0] w, input logic bad, input logic rdy);
    if (par) step(1, 0, (^w) ^ bad, rdy);
  endtask
  task automatic send_word(input logic [7:0] w, input logic rdy, input logic bad);
    for (int i = 7; i >= 0; i--) step(1, i == 7, w[i], rdy);
    send_par(w, bad, rdy);
  endtask
  initial begin
    logic [7:0] w;
    step(0, 0, 0, 0, 0);
    step(1, 1, 1, 1, 0);
    check("reset_q", q_l, 0);
    check("reset_valid", qv_l, 0);
    check("reset_busy", busy_l, 0);
    send_word(8'h1E, 0, 0);
    check("tp_left_q", q_l, 8'h1E);
    check("tp_right_q", q_r, 8'h78);
    check("tp_valid", qv_l, 1);
    check("tp_busy", busy_l, 0);
    step(0, 0, 0, 1);
    check("tp_accept", qv_l, 0);
    send_word(8'h1E, 0, 0);
    send_word(8'hC3, 0, 0);
    check("b2b_q", q_l, 8'h1E);
    check("b2b_overrun", ov_l, 1);
    step(0, 0, 0, 0);
    check("b2b_overrun_pulse", ov_l, 0);
    step(0, 0, 0, 1);
    check("b2b_accept", qv_l, 0);
    for (int i = 0; i < 4; i++) step(1, i == 0, 1'(i), 0);
    w = 8'h55;
    step(1, 1, w[7], 0);
    check("abort_pulse", ab_l, 1);
    for (int i = 6; i >= 0; i--) step(1, 0, w[i], 0);
    send_par(w, 0, 0);
    check("abort_q_left", q_l, 8'h55);
    check("abort_q_right", q_r, 8'hAA);
    check("abort_no_overrun", ov_l, 0);
    step(0, 0, 0, 1);
    w = 8'hA5;
    for (int i = 7; i >= 0; i--) begin
      step(1, i == 7, w[i], 0);
      step(0, 1'($urandom), 1'($urandom), 0);
    end
    send_par(w, 0, 0);
    check("toggle_q", q_l, 8'hA5);
    check("toggle_valid", qv_l, 1);
    step(0, 0, 0, 1);
    for (int i = 0; i < 5; i++) step(1, i == 0, 1'b1, 0);
    step(1, 0, 1, 0, 0);
    check("midreset_q", q_l, 0);
    check("midreset_valid", qv_l, 0);
    check("midreset_busy", busy_l, 0);
    send_word(8'h4B, 0, 0);
    check("post_reset_left", q_l, 8'h4B);
    check("post_reset_right", q_r, 8'hD2);
    step(0, 0, 0, 1);
`ifdef LPM_SIPO_RX_PARITY_EN
    send_word(8'h1E, 0, 0);
    check("parity_good", pe_l, 0);
    step(0, 0, 0, 1);
    for (int i = 7; i >= 0; i--) step(1, i == 7, w[i] ^ 1'b0, 0);
    check("parity_latency", qv_l, 0);
    step(1, 0, ~(^w), 0);
    check("parity_bad", pe_l, 1);
    step(0, 0, 0, 1);
`endif
    for (int n = 0; n < 3000; n++)
      step($urandom_range(0, 9) < 7, $urandom_range(0, 9) == 0, 1'($urandom), 1'($urandom),
           $urandom_range(0, 199) != 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
